// File: rtl/aemb_bus_ctl.sv
// Bus controller for the aemb core: runs one data-wishbone or FSL transaction at a time.
// It stalls the pipeline through gena and aborts a transaction if no acknowledge arrives in time.
module aemb_bus_ctl #(
   parameter int TOUT = 16
) (
   input  logic gclk,
   input  logic grst,
   input  logic req_dwb,
   input  logic req_we,
   input  logic req_fsl,
   input  logic req_nblk,
   input  logic dwb_ack_i,
   input  logic fsl_ack_i,
   output logic dwb_stb_o,
   output logic dwb_we_o,
   output logic fsl_stb_o,
   output logic fsl_we_o,
   output logic gena,
   output logic bus_err,
   output logic fsl_fail
);

   typedef enum logic [1:0] {IDLE, DWB, FSL, DONE} busState_e;

   localparam logic [7:0] toutCnt = 8'(TOUT);

   busState_e  busState;
   logic [7:0] waitCnt;
   logic       nblkReg;

   // The pipeline advances only on the DONE cycle, or when it has nothing to ask of the bus.
   assign gena = (busState == DONE) || ((busState == IDLE) && !req_dwb && !req_fsl);

   // A DONE cycle always separates two transactions, so the request still held
   // during DONE is not taken a second time.
   always_ff @(posedge gclk or posedge grst) begin
      if (grst) begin
         busState  <= IDLE;
         dwb_stb_o <= 1'b0;
         dwb_we_o  <= 1'b0;
         fsl_stb_o <= 1'b0;
         fsl_we_o  <= 1'b0;
         bus_err   <= 1'b0;
         fsl_fail  <= 1'b0;
         waitCnt   <= 8'd0;
         nblkReg   <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         case (busState)
            IDLE: begin
               if (req_dwb) begin
                  busState  <= DWB;
                  dwb_stb_o <= 1'b1;
                  dwb_we_o  <= req_we;
                  waitCnt   <= 8'd1;
               end else if (req_fsl) begin
                  busState  <= FSL;
                  fsl_stb_o <= 1'b1;
                  fsl_we_o  <= req_we;
                  nblkReg   <= req_nblk;
                  waitCnt   <= 8'd1;
               end
            end
            DWB: begin
               if (dwb_ack_i && dwb_stb_o) begin
                  busState  <= DONE;
                  dwb_stb_o <= 1'b0;
                  dwb_we_o  <= 1'b0;
               end else if (waitCnt == toutCnt) begin
                  busState  <= DONE;
                  dwb_stb_o <= 1'b0;
                  dwb_we_o  <= 1'b0;
                  bus_err   <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            FSL: begin
               // An acknowledge wins over both the non-blocking give-up and the timeout.
               if (fsl_ack_i && fsl_stb_o) begin
                  busState  <= DONE;
                  fsl_stb_o <= 1'b0;
                  fsl_we_o  <= 1'b0;
                  fsl_fail  <= 1'b0;
               end else if (nblkReg) begin
                  busState  <= DONE;
                  fsl_stb_o <= 1'b0;
                  fsl_we_o  <= 1'b0;
                  fsl_fail  <= 1'b1;
               end else if (waitCnt == toutCnt) begin
                  busState  <= DONE;
                  fsl_stb_o <= 1'b0;
                  fsl_we_o  <= 1'b0;
                  bus_err   <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            DONE: begin
               busState <= IDLE;
            end
            default: begin
               busState <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aemb_bus_ctl.sv
// Testbench for aemb_bus_ctl: per-cycle vector table checked through an expected-value queue,
// plus hand-written timeout and asynchronous-reset sequences.
module tb_aemb_bus_ctl;

   logic gclk = 1'b0;
   logic grst;
   logic reqDwb, reqWe, reqFsl, reqNblk, dwbAck, fslAck;
   logic dwbStb, dwbWe, fslStb, fslWe, gena, busErr, fslFail;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct packed {
      logic [6:0] stim;
      logic [6:0] expOut;
   } vec_t;

   vec_t vecs[$];
   vec_t pending[$];

   aemb_bus_ctl #(.TOUT(4)) dut (
      .gclk(gclk), .grst(grst),
      .req_dwb(reqDwb), .req_we(reqWe), .req_fsl(reqFsl), .req_nblk(reqNblk),
      .dwb_ack_i(dwbAck), .fsl_ack_i(fslAck),
      .dwb_stb_o(dwbStb), .dwb_we_o(dwbWe), .fsl_stb_o(fslStb), .fsl_we_o(fslWe),
      .gena(gena), .bus_err(busErr), .fsl_fail(fslFail)
   );

   always #5 gclk = ~gclk;

   // stim = {grst, req_dwb, req_we, req_fsl, req_nblk, dwb_ack_i, fsl_ack_i}
   // expOut = {dwb_stb_o, dwb_we_o, fsl_stb_o, fsl_we_o, gena, bus_err, fsl_fail}
   task automatic addVec(input logic [6:0] stim, input logic [6:0] expOut);
      vec_t v;
      v.stim   = stim;
      v.expOut = expOut;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge gclk);
      #1;
      {grst, reqDwb, reqWe, reqFsl, reqNblk, dwbAck, fslAck} = v.stim;
      pending.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   initial begin
      vec_t v;
      int stbCount, errCount;
      logic seenGena;

      grst = 1'b1;
      {reqDwb, reqWe, reqFsl, reqNblk, dwbAck, fslAck} = '0;

      // reset, then idle
      addVec(7'b1000000, 7'b0000100);
      addVec(7'b0000000, 7'b0000100);
      // load, acknowledged on first strobe
      addVec(7'b0100000, 7'b0000000);
      addVec(7'b0100010, 7'b1000000);
      addVec(7'b0100000, 7'b0000100);
      addVec(7'b0000000, 7'b0000100);
      // store, acknowledged on second strobe
      addVec(7'b0110000, 7'b0000000);
      addVec(7'b0110000, 7'b1100000);
      addVec(7'b0110010, 7'b1100000);
      addVec(7'b0110000, 7'b0000100);
      addVec(7'b0000000, 7'b0000100);
      // put with three wait states, ack coincides with counter == TOUT
      addVec(7'b0011000, 7'b0000000);
      addVec(7'b0011000, 7'b0011000);
      addVec(7'b0011000, 7'b0011000);
      addVec(7'b0011000, 7'b0011000);
      addVec(7'b0011001, 7'b0011000);
      addVec(7'b0011000, 7'b0000100);
      addVec(7'b0000000, 7'b0000100);
      // non-blocking get, never acknowledged
      addVec(7'b0001100, 7'b0000000);
      addVec(7'b0001100, 7'b0010000);
      addVec(7'b0001100, 7'b0000101);
      addVec(7'b0000000, 7'b0000101);
      // load timeout: fsl_fail keeps its value
      addVec(7'b0100000, 7'b0000001);
      addVec(7'b0100000, 7'b1000001);
      addVec(7'b0100000, 7'b1000001);
      addVec(7'b0100000, 7'b1000001);
      addVec(7'b0100000, 7'b1000001);
      addVec(7'b0100000, 7'b0000111);
      addVec(7'b0000000, 7'b0000101);
      // load acked in the fourth strobe cycle: normal completion
      addVec(7'b0100000, 7'b0000001);
      addVec(7'b0100000, 7'b1000001);
      addVec(7'b0100000, 7'b1000001);
      addVec(7'b0100000, 7'b1000001);
      addVec(7'b0100010, 7'b1000001);
      addVec(7'b0100000, 7'b0000101);
      addVec(7'b0000000, 7'b0000101);
      // blocking get acked clears fsl_fail
      addVec(7'b0001000, 7'b0000001);
      addVec(7'b0001001, 7'b0010001);
      addVec(7'b0001000, 7'b0000100);
      addVec(7'b0000000, 7'b0000100);
      // simultaneous requests: data bus wins, stray acks ignored
      addVec(7'b0111000, 7'b0000000);
      addVec(7'b0111011, 7'b1100000);
      addVec(7'b0111001, 7'b0000100);
      addVec(7'b0000011, 7'b0000100);
      addVec(7'b0000000, 7'b0000100);
      // reset in the second strobe cycle, late ack afterwards
      addVec(7'b0100000, 7'b0000000);
      addVec(7'b0100000, 7'b1000000);
      addVec(7'b1100000, 7'b0000000);
      addVec(7'b0000010, 7'b0000100);
      addVec(7'b0000000, 7'b0000100);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge gclk);
         if (pending.size() == 0) begin
            checkOutput($sformatf("queue%0d", i), 8'd0, 8'd1);
         end else begin
            v = pending.pop_front();
            checkOutput($sformatf("vec%0d", i),
                        {1'b0, dwbStb, dwbWe, fslStb, fslWe, gena, busErr, fslFail},
                        {1'b0, v.expOut});
         end
      end

      // timeout counted end to end: strobe lasts TOUT cycles, exactly one bus_err
      stbCount = 0;
      errCount = 0;
      seenGena = 1'b0;
      @(posedge gclk);
      #1;
      {grst, reqDwb, reqWe, reqFsl, reqNblk, dwbAck, fslAck} = 7'b0100000;
      for (int i = 0; i < 12; i++) begin
         @(negedge gclk);
         if (dwbStb) stbCount++;
         if (busErr) errCount++;
         if (gena && !seenGena) begin
            seenGena = 1'b1;
            @(posedge gclk);
            #1;
            reqDwb = 1'b0;
         end
      end
      checkOutput("toutDone", {7'd0, seenGena}, 8'd1);
      checkOutput("toutStbCycles", 8'(stbCount), 8'd4);
      checkOutput("toutErrPulses", 8'(errCount), 8'd1);

      // reset drops the strobe between clock edges
      @(posedge gclk);
      #1;
      reqDwb = 1'b1;
      @(posedge gclk);
      #1;
      checkOutput("rstPreStb", {7'd0, dwbStb}, 8'd1);
      #2;
      grst = 1'b1;
      #1;
      checkOutput("rstAsyncStb", {7'd0, dwbStb}, 8'd0);
      @(posedge gclk);
      #1;
      grst   = 1'b0;
      reqDwb = 1'b0;
      dwbAck = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge gclk);
         checkOutput($sformatf("rstNoResume%0d", i), {7'd0, dwbStb}, 8'd0);
      end
      dwbAck = 1'b0;
      @(negedge gclk);
      checkOutput("rstGenaIdle", {7'd0, gena}, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
